// File: rtl/traffic_light_ctrl_pkg.sv
// Shared lamp codes, controller state encoding and approach directions.
package traffic_pkg;

  typedef enum logic [2:0] {
    LAMP_OFF    = 3'b000,
    LAMP_GREEN  = 3'b001,
    LAMP_YELLOW = 3'b010,
    LAMP_RED    = 3'b100
  } lamp_t;

  typedef enum logic [3:0] {
    NS_G  = 4'd0,
    NS_Y  = 4'd1,
    AR_NS = 4'd2,
    EW_G  = 4'd3,
    EW_Y  = 4'd4,
    AR_EW = 4'd5,
    PED   = 4'd6,
    FLASH = 4'd7,
    EMG   = 4'd8
  } state_t;

  localparam logic DIR_NS = 1'b0;
  localparam logic DIR_EW = 1'b1;

endpackage

// File: rtl/traffic_light_ctrl_if.sv
// Request inputs and lamp/status outputs of the intersection controller.
interface traffic_light_ctrl_if;
  import traffic_pkg::*;

  logic   night_mode;
  logic   ped_req;
  logic   emerg_req;
  logic   emerg_dir;
  lamp_t  n_light;
  lamp_t  s_light;
  lamp_t  e_light;
  lamp_t  w_light;
  logic   walk;
  state_t phase;

  modport master (
    output night_mode, ped_req, emerg_req, emerg_dir,
    input  n_light, s_light, e_light, w_light, walk, phase
  );

  modport slave (
    input  night_mode, ped_req, emerg_req, emerg_dir,
    output n_light, s_light, e_light, w_light, walk, phase
  );

endinterface

// File: rtl/traffic_light_ctrl_timer.sv
// Dwell down-counter: load on phase entry, count to zero and hold there; expire while zero.
module phase_timer #(
  parameter int unsigned         CNT_W   = 8,
  parameter logic [CNT_W-1:0]    RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_expire
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= RST_VAL;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_expire = (r_cnt == '0);

endmodule

// File: rtl/traffic_light_ctrl.sv
// Four-way intersection controller: NS/EW cycle, latched walk phase, night flash, emergency pre-emption.
// Lamp outputs are Moore, decoded from the state register.
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned T_GREEN_NS = 6,
  parameter int unsigned T_GREEN_EW = 6,
  parameter int unsigned T_YELLOW   = 4,
  parameter int unsigned T_ALLRED   = 1,
  parameter int unsigned T_PED      = 8,
  parameter int unsigned T_FLASH    = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  traffic_light_ctrl_if.slave  io_tl
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_emg_dir;
  logic             w_emg_dir_nxt;
  logic             r_next_dir;
  logic             r_ped_pend;
  logic             r_flash_on;
  logic             w_expire;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  lamp_t            w_ns;
  lamp_t            w_ew;
  logic             w_walk;

  function automatic logic [CNT_W-1:0] dwell_m1(input state_t s);
    int unsigned t;
    case (s)
      NS_G:        t = T_GREEN_NS;
      EW_G:        t = T_GREEN_EW;
      NS_Y, EW_Y:  t = T_YELLOW;
      AR_NS, AR_EW: t = T_ALLRED;
      PED:         t = T_PED;
      FLASH:       t = T_FLASH;
      default:     t = 1;
    endcase
    return CNT_W'(t - 1);
  endfunction

  // FLASH reloads on its own expiry to produce the on/off half-periods.
  assign w_load     = (w_state_nxt != r_state) || ((r_state == FLASH) && w_expire);
  assign w_load_val = (w_state_nxt == EMG) ? '0 : dwell_m1(w_state_nxt);

  phase_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (CNT_W'(T_GREEN_NS - 1))
  ) u_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_expire   (w_expire)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= NS_G;
      r_emg_dir  <= DIR_NS;
      r_next_dir <= DIR_EW;
      r_ped_pend <= 1'b0;
      r_flash_on <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_emg_dir <= w_emg_dir_nxt;
      if (r_state == AR_NS) r_next_dir <= DIR_EW;
      else if (r_state == AR_EW) r_next_dir <= DIR_NS;
      if (io_tl.ped_req && (r_state != PED)) r_ped_pend <= 1'b1;
      else if ((r_state == PED) && w_expire) r_ped_pend <= 1'b0;
      if (r_state != FLASH) r_flash_on <= 1'b1;
      else if (w_expire) r_flash_on <= ~r_flash_on;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_emg_dir_nxt = r_emg_dir;
    w_ns          = LAMP_RED;
    w_ew          = LAMP_RED;
    w_walk        = 1'b0;
    case (r_state)
      NS_G: begin
        w_ns = LAMP_GREEN;
        if (io_tl.emerg_req && (io_tl.emerg_dir == DIR_EW)) begin
          w_state_nxt = NS_Y;
        end else if (io_tl.emerg_req) begin
          w_state_nxt   = EMG;
          w_emg_dir_nxt = DIR_NS;
        end else if (w_expire) begin
          w_state_nxt = NS_Y;
        end
      end
      NS_Y: begin
        w_ns = LAMP_YELLOW;
        if (w_expire) w_state_nxt = AR_NS;
      end
      EW_G: begin
        w_ew = LAMP_GREEN;
        if (io_tl.emerg_req && (io_tl.emerg_dir == DIR_NS)) begin
          w_state_nxt = EW_Y;
        end else if (io_tl.emerg_req) begin
          w_state_nxt   = EMG;
          w_emg_dir_nxt = DIR_EW;
        end else if (w_expire) begin
          w_state_nxt = EW_Y;
        end
      end
      EW_Y: begin
        w_ew = LAMP_YELLOW;
        if (w_expire) w_state_nxt = AR_EW;
      end
      AR_NS, AR_EW: begin
        if (w_expire) begin
          if (io_tl.emerg_req) begin
            w_state_nxt   = EMG;
            w_emg_dir_nxt = io_tl.emerg_dir;
          end else if (io_tl.night_mode) begin
            w_state_nxt = FLASH;
          end else if (r_ped_pend) begin
            w_state_nxt = PED;
          end else begin
            w_state_nxt = (r_state == AR_NS) ? EW_G : NS_G;
          end
        end
      end
      PED: begin
        w_walk = 1'b1;
        if (w_expire) w_state_nxt = (r_next_dir == DIR_NS) ? NS_G : EW_G;
      end
      EMG: begin
        if (r_emg_dir == DIR_NS) w_ns = LAMP_GREEN;
        else w_ew = LAMP_GREEN;
        if (!io_tl.emerg_req) w_state_nxt = (r_emg_dir == DIR_NS) ? NS_Y : EW_Y;
      end
      FLASH: begin
        w_ns = r_flash_on ? LAMP_YELLOW : LAMP_OFF;
        w_ew = r_flash_on ? LAMP_YELLOW : LAMP_OFF;
        if (!io_tl.night_mode || io_tl.emerg_req) w_state_nxt = AR_EW;
      end
      default: w_state_nxt = NS_G;
    endcase
  end

  assign io_tl.n_light = w_ns;
  assign io_tl.s_light = w_ns;
  assign io_tl.e_light = w_ew;
  assign io_tl.w_light = w_ew;
  assign io_tl.walk    = w_walk;
  assign io_tl.phase   = r_state;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench: table of per-segment stimulus/expected lamps fed through a scoreboard, plus a
// short-dwell instance under random requests watched for NS/EW conflicts.
module tb_traffic_light_ctrl;
  import traffic_pkg::*;

  localparam lamp_t G = LAMP_GREEN;
  localparam lamp_t Y = LAMP_YELLOW;
  localparam lamp_t R = LAMP_RED;
  localparam lamp_t O = LAMP_OFF;

  typedef struct {
    bit     sel;
    logic   rst, night, ped, emg, dir;
    state_t ph;
    lamp_t  ns, ew;
    logic   walk;
    int     n;
  } row_t;

  typedef struct {
    bit     sel;
    state_t ph;
    lamp_t  ns, ew;
    logic   walk;
  } exp_t;

  logic clk;
  logic rst_a, rst_b;
  bit   mon_en;
  int   checks, errors;
  row_t rows[$];
  exp_t sbq[$];

  traffic_light_ctrl_if bus_a();
  traffic_light_ctrl_if bus_b();

  traffic_light_ctrl dut_a (.i_clk(clk), .i_rst(rst_a), .io_tl(bus_a));

  traffic_light_ctrl #(
    .CNT_W(3), .T_GREEN_NS(1), .T_GREEN_EW(1), .T_YELLOW(1),
    .T_ALLRED(1), .T_PED(1), .T_FLASH(1)
  ) dut_b (.i_clk(clk), .i_rst(rst_b), .io_tl(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string nm, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
    end
  endfunction

  function automatic bit lit(input lamp_t l);
    return (l == LAMP_GREEN) || (l == LAMP_YELLOW);
  endfunction

  task automatic add(input bit sel, input logic rst, night, ped, emg, dir,
                     input state_t ph, input lamp_t ns, ew, input logic walk, input int n);
    rows.push_back('{sel, rst, night, ped, emg, dir, ph, ns, ew, walk, n});
  endtask

  task automatic apply(input row_t r);
    for (int k = 0; k < r.n; k++) begin
      if (!r.sel) begin
        rst_a = r.rst; bus_a.night_mode = r.night; bus_a.ped_req = r.ped;
        bus_a.emerg_req = r.emg; bus_a.emerg_dir = r.dir;
      end else begin
        rst_b = r.rst; bus_b.night_mode = r.night; bus_b.ped_req = r.ped;
        bus_b.emerg_req = r.emg; bus_b.emerg_dir = r.dir;
      end
      sbq.push_back('{r.sel, r.ph, r.ns, r.ew, r.walk});
      @(posedge clk); #1;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      if (!e.sel) begin
        chk("phase_a", bus_a.phase, e.ph);
        chk("ns_lamp_a", bus_a.n_light, e.ns);
        chk("ew_lamp_a", bus_a.e_light, e.ew);
        chk("walk_a", bus_a.walk, e.walk);
      end else begin
        chk("phase_b", bus_b.phase, e.ph);
        chk("ns_lamp_b", bus_b.n_light, e.ns);
        chk("ew_lamp_b", bus_b.e_light, e.ew);
        chk("walk_b", bus_b.walk, e.walk);
      end
    end
    if (mon_en) begin
      chk("s_eq_n_a", bus_a.s_light, bus_a.n_light);
      chk("w_eq_e_a", bus_a.w_light, bus_a.e_light);
      chk("s_eq_n_b", bus_b.s_light, bus_b.n_light);
      chk("w_eq_e_b", bus_b.w_light, bus_b.e_light);
      chk("conflict_a", int'(lit(bus_a.n_light) && lit(bus_a.e_light) &&
          !(bus_a.phase == FLASH && bus_a.n_light == LAMP_YELLOW && bus_a.e_light == LAMP_YELLOW)), 0);
      chk("conflict_b", int'(lit(bus_b.n_light) && lit(bus_b.e_light) &&
          !(bus_b.phase == FLASH && bus_b.n_light == LAMP_YELLOW && bus_b.e_light == LAMP_YELLOW)), 0);
    end
  end

  initial begin
    checks = 0; errors = 0; mon_en = 1'b0;
    rst_a = 1'b1; rst_b = 1'b1;
    bus_a.night_mode = 0; bus_a.ped_req = 0; bus_a.emerg_req = 0; bus_a.emerg_dir = 0;
    bus_b.night_mode = 0; bus_b.ped_req = 0; bus_b.emerg_req = 0; bus_b.emerg_dir = 0;

    //  sel rst ngt ped emg dir  phase  ns ew wk  n
    add(0, 1, 0, 0, 0, 0, NS_G,  G, R, 0, 2);
    for (int i = 0; i < 2; i++) begin
      add(0, 0, 0, 0, 0, 0, NS_G,  G, R, 0, 6);
      add(0, 0, 0, 0, 0, 0, NS_Y,  Y, R, 0, 4);
      add(0, 0, 0, 0, 0, 0, AR_NS, R, R, 0, 1);
      add(0, 0, 0, 0, 0, 0, EW_G,  R, G, 0, 6);
      add(0, 0, 0, 0, 0, 0, EW_Y,  R, Y, 0, 4);
      add(0, 0, 0, 0, 0, 0, AR_EW, R, R, 0, 1);
    end
    // pedestrian pulse in NS green cycle 2; a second press during PED is ignored
    add(0, 0, 0, 0, 0, 0, NS_G,  G, R, 0, 1);
    add(0, 0, 0, 1, 0, 0, NS_G,  G, R, 0, 1);
    add(0, 0, 0, 0, 0, 0, NS_G,  G, R, 0, 4);
    add(0, 0, 0, 0, 0, 0, NS_Y,  Y, R, 0, 4);
    add(0, 0, 0, 0, 0, 0, AR_NS, R, R, 0, 1);
    add(0, 0, 0, 0, 0, 0, PED,   R, R, 1, 3);
    add(0, 0, 0, 1, 0, 0, PED,   R, R, 1, 1);
    add(0, 0, 0, 0, 0, 0, PED,   R, R, 1, 4);
    add(0, 0, 0, 0, 0, 0, EW_G,  R, G, 0, 6);
    add(0, 0, 0, 0, 0, 0, EW_Y,  R, Y, 0, 4);
    add(0, 0, 0, 0, 0, 0, AR_EW, R, R, 0, 1);
    // EW emergency truncates NS green; direction change during EMG is not sampled
    add(0, 0, 0, 0, 1, 1, NS_G,  G, R, 0, 1);
    add(0, 0, 0, 0, 1, 1, NS_Y,  Y, R, 0, 4);
    add(0, 0, 0, 0, 1, 1, AR_NS, R, R, 0, 1);
    add(0, 0, 0, 0, 1, 0, EMG,   R, G, 0, 4);
    add(0, 0, 0, 0, 0, 0, EMG,   R, G, 0, 1);
    add(0, 0, 0, 0, 0, 0, EW_Y,  R, Y, 0, 4);
    add(0, 0, 0, 0, 0, 0, AR_EW, R, R, 0, 1);
    // NS emergency during NS green goes straight to EMG
    add(0, 0, 0, 0, 0, 0, NS_G,  G, R, 0, 2);
    add(0, 0, 0, 0, 1, 0, NS_G,  G, R, 0, 1);
    add(0, 0, 0, 0, 1, 0, EMG,   G, R, 0, 3);
    add(0, 0, 0, 0, 0, 0, EMG,   G, R, 0, 1);
    add(0, 0, 0, 0, 0, 0, NS_Y,  Y, R, 0, 4);
    add(0, 0, 0, 0, 0, 0, AR_NS, R, R, 0, 1);
    // night mode waits for all-red, flashes 2 on / 2 off
    add(0, 0, 1, 0, 0, 0, EW_G,  R, G, 0, 6);
    add(0, 0, 1, 0, 0, 0, EW_Y,  R, Y, 0, 4);
    add(0, 0, 1, 0, 0, 0, AR_EW, R, R, 0, 1);
    add(0, 0, 1, 0, 0, 0, FLASH, Y, Y, 0, 2);
    add(0, 0, 1, 0, 0, 0, FLASH, O, O, 0, 2);
    add(0, 0, 1, 0, 0, 0, FLASH, Y, Y, 0, 2);
    add(0, 0, 0, 0, 0, 0, FLASH, O, O, 0, 1);
    add(0, 0, 0, 0, 0, 0, AR_EW, R, R, 0, 1);
    // reset mid-FLASH
    add(0, 0, 1, 0, 0, 0, NS_G,  G, R, 0, 6);
    add(0, 0, 1, 0, 0, 0, NS_Y,  Y, R, 0, 4);
    add(0, 0, 1, 0, 0, 0, AR_NS, R, R, 0, 1);
    add(0, 0, 1, 0, 0, 0, FLASH, Y, Y, 0, 2);
    add(0, 1, 1, 0, 0, 0, FLASH, O, O, 0, 1);
    add(0, 0, 0, 0, 0, 0, NS_G,  G, R, 0, 6);
    add(0, 0, 0, 0, 0, 0, NS_Y,  Y, R, 0, 4);
    add(0, 0, 0, 0, 0, 0, AR_NS, R, R, 0, 1);
    add(0, 0, 0, 0, 0, 0, EW_G,  R, G, 0, 6);
    add(0, 0, 0, 0, 0, 0, EW_Y,  R, Y, 0, 4);
    add(0, 0, 0, 0, 0, 0, AR_EW, R, R, 0, 1);
    // reset mid-EMG also drops a pending pedestrian request
    add(0, 0, 0, 1, 1, 0, NS_G,  G, R, 0, 1);
    add(0, 0, 0, 0, 1, 0, EMG,   G, R, 0, 2);
    add(0, 1, 0, 0, 1, 0, EMG,   G, R, 0, 1);
    add(0, 0, 0, 0, 0, 0, NS_G,  G, R, 0, 6);
    add(0, 0, 0, 0, 0, 0, NS_Y,  Y, R, 0, 4);
    add(0, 0, 0, 0, 0, 0, AR_NS, R, R, 0, 1);
    add(0, 0, 0, 0, 0, 0, EW_G,  R, G, 0, 2);
    // single-cycle dwell instance
    add(1, 1, 0, 0, 0, 0, NS_G,  G, R, 0, 1);
    for (int i = 0; i < 2; i++) begin
      add(1, 0, 0, 0, 0, 0, NS_G,  G, R, 0, 1);
      add(1, 0, 0, 0, 0, 0, NS_Y,  Y, R, 0, 1);
      add(1, 0, 0, 0, 0, 0, AR_NS, R, R, 0, 1);
      add(1, 0, 0, 0, 0, 0, EW_G,  R, G, 0, 1);
      add(1, 0, 0, 0, 0, 0, EW_Y,  R, Y, 0, 1);
      add(1, 0, 0, 0, 0, 0, AR_EW, R, R, 0, 1);
    end

    @(posedge clk); #1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    foreach (rows[i]) apply(rows[i]);

    rst_a = 1'b1;
    for (int c = 0; c < 400; c++) begin
      bus_b.night_mode = ($urandom_range(0, 7) == 0);
      bus_b.ped_req    = ($urandom_range(0, 3) == 0);
      bus_b.emerg_req  = ($urandom_range(0, 4) == 0);
      bus_b.emerg_dir  = 1'($urandom_range(0, 1));
      rst_b            = ($urandom_range(0, 99) == 0);
      @(posedge clk); #1;
    end

    @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
